// File: rtl/eth_phy_10g_tx_sh_inject.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_tx_sh_inject
//
// Purpose:
//   Sits between the 64b/66b TX encoder/scrambler and the SERDES. It registers
//   the block payload and the sync header on their way out. It can also
//   deliberately corrupt sync headers in a programmable pattern. The pattern
//   is used to exercise block-lock acquisition and loss in a paired receiver.
//
//   An injection run is made of periods. Each period has
//   cfg_valid_cnt untouched blocks followed by cfg_invalid_cnt blocks whose
//   header is replaced by 2'b00 or 2'b11. A run lasts cfg_repeat periods, or
//   runs until abort when cfg_repeat is 0.
//
// Ports:
//   tx_clk          - sole clock; every state update happens on its rising edge
//   tx_rst_n        - asynchronous active-low reset, released synchronously
//   in_data         - block payload from the TX encoder
//   in_hdr          - block sync header (2'b01 data, 2'b10 control)
//   serdes_tx_data  - in_data delayed by one cycle
//   serdes_tx_hdr   - in_hdr delayed by one cycle, corrupted while INVALID
//   start           - one-cycle pulse that launches a run (ignored when busy)
//   abort           - forces IDLE on the next edge, without a done pulse
//   cfg_valid_cnt   - untouched blocks per period (0..127)
//   cfg_invalid_cnt - corrupted blocks per period (0..63)
//   cfg_repeat      - periods per run, 0 = run until abort
//   cfg_bad_hdr     - corrupt header value: 0 -> 2'b00, 1 -> 2'b11
//   busy            - high while the FSM is not IDLE
//   done            - one-cycle pulse when a run completes normally
//   inj_count       - saturating count of corrupted headers emitted
//
// Configuration:
//   ETH_PHY_TX_SH_INJECT_CNT_EN - when defined, inj_count is a live
//   saturating counter. When undefined, inj_count is tied to 0 and no
//   counter logic is built.
// -----------------------------------------------------------------------------
module eth_phy_10g_tx_sh_inject #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    input  logic                  start,
    input  logic                  abort,
    input  logic [6:0]            cfg_valid_cnt,
    input  logic [5:0]            cfg_invalid_cnt,
    input  logic [3:0]            cfg_repeat,
    input  logic                  cfg_bad_hdr,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           inj_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VALID   = 2'd1,
        INVALID = 2'd2
    } state_t;

    localparam logic [HDR_WIDTH-1:0] HDR_DATA = HDR_WIDTH'(1);

    state_t     state;
    logic [6:0] phase_cnt;
    logic [3:0] period_left;
    logic [6:0] lat_valid;
    logic [5:0] lat_invalid;
    logic [3:0] lat_repeat;
    logic       lat_bad_hdr;

    logic       valid_last;
    logic       invalid_last;
    logic       period_end;
    logic       period_final;
    state_t     restart_state;

    // Period bookkeeping decoded from the counters. phase_cnt counts cycles
    // spent in the current VALID/INVALID phase. A phase ends when phase_cnt
    // reaches the latched length minus one. The period ends after INVALID,
    // or directly after VALID when no corrupted blocks are configured. A
    // repeat value of 0 never reaches the final period.
    always_comb begin
        valid_last    = 1'b0;
        invalid_last  = 1'b0;
        period_end    = 1'b0;
        period_final  = 1'b0;
        restart_state = VALID;

        valid_last    = (phase_cnt == (lat_valid - 7'd1));
        invalid_last  = (phase_cnt == {1'b0, (lat_invalid - 6'd1)});
        period_end    = ((state == VALID) && valid_last && (lat_invalid == 6'd0)) ||
                        ((state == INVALID) && invalid_last);
        period_final  = (lat_repeat != 4'd0) && (period_left == 4'd1);
        restart_state = (lat_valid == 7'd0) ? INVALID : VALID;
    end

    // Injection FSM. cfg_* is captured only when a run starts, so later
    // changes cannot disturb a run in progress. abort is checked before
    // anything else, so it beats a simultaneous start. busy and done are
    // registered together with the state so they change on the same edge.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state       <= IDLE;
            phase_cnt   <= 7'd0;
            period_left <= 4'd0;
            lat_valid   <= 7'd0;
            lat_invalid <= 6'd0;
            lat_repeat  <= 4'd0;
            lat_bad_hdr <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state       <= IDLE;
                busy        <= 1'b0;
                phase_cnt   <= 7'd0;
                period_left <= 4'd0;
            end else if (period_end) begin
                phase_cnt <= 7'd0;
                if (period_final) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    period_left <= 4'd0;
                end else begin
                    if (lat_repeat != 4'd0) begin
                        period_left <= period_left - 4'd1;
                    end
                    state <= restart_state;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            lat_valid   <= cfg_valid_cnt;
                            lat_invalid <= cfg_invalid_cnt;
                            lat_repeat  <= cfg_repeat;
                            lat_bad_hdr <= cfg_bad_hdr;
                            period_left <= cfg_repeat;
                            phase_cnt   <= 7'd0;
                            if (cfg_valid_cnt != 7'd0) begin
                                state <= VALID;
                                busy  <= 1'b1;
                            end else if (cfg_invalid_cnt != 6'd0) begin
                                state <= INVALID;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    VALID: begin
                        if (valid_last) begin
                            phase_cnt <= 7'd0;
                            state     <= INVALID;
                        end else begin
                            phase_cnt <= phase_cnt + 7'd1;
                        end
                    end
                    INVALID: begin
                        phase_cnt <= phase_cnt + 7'd1;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output pipeline. The payload is always passed through with one cycle
    // of delay. The header is replaced by the bad pattern whenever the FSM
    // is in INVALID during the cycle in which the header is sampled. This
    // includes the cycle in which abort is being applied.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            serdes_tx_data <= '0;
            serdes_tx_hdr  <= HDR_DATA;
        end else begin
            serdes_tx_data <= in_data;
            if (state == INVALID) begin
                serdes_tx_hdr <= {HDR_WIDTH{lat_bad_hdr}};
            end else begin
                serdes_tx_hdr <= in_hdr;
            end
        end
    end

`ifdef ETH_PHY_TX_SH_INJECT_CNT_EN
    // Corrupted-header counter. It counts one per INVALID cycle and sticks at
    // all-ones rather than wrapping. Only reset clears it, so it accumulates
    // across runs.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            inj_count <= 16'd0;
        end else if ((state == INVALID) && (inj_count != 16'hFFFF)) begin
            inj_count <= inj_count + 16'd1;
        end
    end
`else
    assign inj_count = 16'd0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_tx_sh_inject.sv
// -----------------------------------------------------------------------------
// tb_eth_phy_10g_tx_sh_inject
//
// Purpose:
//   Directed self-checking bench for eth_phy_10g_tx_sh_inject. Each run
//   starts the injector and then compares every output cycle against a small
//   model of the expected pattern. In each period, the block at index j is
//   corrupted when (j mod (valid+invalid)) >= valid. The done pulse is
//   expected only in the cycle after the last block of the final period.
//
// Ports: none (top-level bench).
// Configuration: honours ETH_PHY_TX_SH_INJECT_CNT_EN for inj_count expectations.
// -----------------------------------------------------------------------------
module tb_eth_phy_10g_tx_sh_inject;

    localparam int DW = 64;
    localparam int HW = 2;

`ifdef ETH_PHY_TX_SH_INJECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          tx_clk = 1'b0;
    logic          tx_rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [HW-1:0] in_hdr = 2'b01;
    logic [DW-1:0] serdes_tx_data;
    logic [HW-1:0] serdes_tx_hdr;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [6:0]    cfg_valid_cnt = '0;
    logic [5:0]    cfg_invalid_cnt = '0;
    logic [3:0]    cfg_repeat = '0;
    logic          cfg_bad_hdr = 1'b0;
    logic          busy;
    logic          done;
    logic [15:0]   inj_count;

    int            total_cnt = 0;
    int            bad_cnt = 0;
    int            exp_inj = 0;
    logic [DW-1:0] sent_data;
    logic [HW-1:0] sent_hdr;

    eth_phy_10g_tx_sh_inject #(
        .DATA_WIDTH(DW),
        .HDR_WIDTH (HW)
    ) dut (
        .tx_clk         (tx_clk),
        .tx_rst_n       (tx_rst_n),
        .in_data        (in_data),
        .in_hdr         (in_hdr),
        .serdes_tx_data (serdes_tx_data),
        .serdes_tx_hdr  (serdes_tx_hdr),
        .start          (start),
        .abort          (abort),
        .cfg_valid_cnt  (cfg_valid_cnt),
        .cfg_invalid_cnt(cfg_invalid_cnt),
        .cfg_repeat     (cfg_repeat),
        .cfg_bad_hdr    (cfg_bad_hdr),
        .busy           (busy),
        .done           (done),
        .inj_count      (inj_count)
    );

    // 100 MHz clock.
    always #5 tx_clk = ~tx_clk;

    // Single comparison point. Every check is counted, and mismatches are
    // reported with the observed and expected values.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // New random payload and a legal data/control header for the next cycle.
    task automatic driveInputs();
        sent_data = {$urandom, $urandom};
        sent_hdr  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        in_data   = sent_data;
        in_hdr    = sent_hdr;
    endtask

    // Latch a configuration with a one-cycle start pulse. Afterwards the cfg
    // inputs are scrambled, which shows that the run keeps its latched values.
    task automatic applyStimulus(input int v, input int i, input int r, input logic bad);
        cfg_valid_cnt   = 7'(v);
        cfg_invalid_cnt = 6'(i);
        cfg_repeat      = 4'(r);
        cfg_bad_hdr     = bad;
        start           = 1'b1;
        @(posedge tx_clk);
        #1;
        start           = 1'b0;
        cfg_valid_cnt   = 7'd1;
        cfg_invalid_cnt = 6'd1;
        cfg_repeat      = 4'd1;
        cfg_bad_hdr     = ~bad;
        driveInputs();
    endtask

    // Observe a run cycle by cycle and count deviations from the model.
    // restart_at >= 0 pulses a second start, with a different config, at that
    // cycle. The running FSM must ignore it.
    task automatic watchRun(input int v, input int i, input int r, input logic bad,
                            input int cycles, input int restart_at,
                            output int hdr_err, output int data_err,
                            output int busy_err, output int done_cnt);
        int            p;
        int            tot;
        logic [HW-1:0] badh;
        logic [HW-1:0] exph;
        logic [DW-1:0] expd;
        logic          exp_done;
        logic          exp_busy;
        p        = v + i;
        tot      = r * p;
        badh     = bad ? 2'b11 : 2'b00;
        hdr_err  = 0;
        data_err = 0;
        busy_err = 0;
        done_cnt = 0;
        for (int j = 0; j < cycles; j++) begin
            exph     = ((r == 0 || j < tot) && ((j % p) >= v)) ? badh : sent_hdr;
            expd     = sent_data;
            exp_done = (r != 0) && (j == tot - 1);
            exp_busy = (r == 0) || (j + 1 < tot);
            if (j == restart_at) begin
                cfg_valid_cnt   = 7'd2;
                cfg_invalid_cnt = 6'd9;
                cfg_repeat      = 4'd1;
                start           = 1'b1;
            end
            @(posedge tx_clk);
            #1;
            start = 1'b0;
            if (serdes_tx_hdr !== exph) begin
                if (hdr_err == 0)
                    $display("[TB] first hdr deviation at cycle %0d: got %b want %b", j, serdes_tx_hdr, exph);
                hdr_err++;
            end
            if (serdes_tx_data !== expd) data_err++;
            if (busy !== exp_busy) busy_err++;
            if (done === 1'b1) done_cnt++;
            if (done !== exp_done) busy_err++;
            driveInputs();
        end
    endtask

    // Runs a full, normally terminating run and checks its aggregates.
    task automatic fullRun(input string name, input int v, input int i, input int r,
                           input logic bad, input int restart_at);
        int he, de, be, dc;
        applyStimulus(v, i, r, bad);
        watchRun(v, i, r, bad, r * (v + i) + 3, restart_at, he, de, be, dc);
        exp_inj += CNT_EN ? r * i : 0;
        checkOutput({name, "_hdr_err"}, 64'(he), 64'd0);
        checkOutput({name, "_data_err"}, 64'(de), 64'd0);
        checkOutput({name, "_busy_done_err"}, 64'(be), 64'd0);
        checkOutput({name, "_done_cnt"}, 64'(dc), 64'd1);
        checkOutput({name, "_inj_count"}, 64'(inj_count), 64'(exp_inj));
    endtask

    // Directed sequence: reset values, the documented injection patterns,
    // zero-length runs, abort handling and reset in the middle of a run.
    initial begin
        int he, de, be, dc;
        int done_seen;
        driveInputs();

        repeat (3) @(posedge tx_clk);
        #1;
        checkOutput("rst_data", 64'(serdes_tx_data), 64'd0);
        checkOutput("rst_hdr", 64'(serdes_tx_hdr), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_inj", 64'(inj_count), 64'd0);
        tx_rst_n = 1'b1;
        @(posedge tx_clk);
        #1;
        driveInputs();

        fullRun("v64i1r5", 64, 1, 5, 1'b0, -1);
        fullRun("v64i15r5", 64, 15, 5, 1'b1, -1);
        fullRun("v64i16r1", 64, 16, 1, 1'b0, -1);
        fullRun("restart_ignored", 5, 2, 3, 1'b0, 4);

        // Both counts zero: done pulses on the next edge and busy never rises.
        applyStimulus(0, 0, 2, 1'b0);
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        @(posedge tx_clk);
        #1;
        checkOutput("zero_done_drop", 64'(done), 64'd0);

        // abort beats a simultaneous start.
        cfg_valid_cnt   = 7'd3;
        cfg_invalid_cnt = 6'd3;
        cfg_repeat      = 4'd1;
        start           = 1'b1;
        abort           = 1'b1;
        @(posedge tx_clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_busy", 64'(busy), 64'd0);
        checkOutput("abort_start_done", 64'(done), 64'd0);
        driveInputs();

        // Endless all-invalid run, aborted in its 11th cycle.
        applyStimulus(0, 3, 0, 1'b1);
        watchRun(0, 3, 0, 1'b1, 10, -1, he, de, be, dc);
        checkOutput("endless_hdr_err", 64'(he), 64'd0);
        checkOutput("endless_data_err", 64'(de), 64'd0);
        checkOutput("endless_busy_err", 64'(be), 64'd0);
        abort = 1'b1;
        @(posedge tx_clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_hdr", 64'(serdes_tx_hdr), 64'd3);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        driveInputs();
        @(posedge tx_clk);
        #1;
        checkOutput("post_abort_hdr", 64'(serdes_tx_hdr), 64'(sent_hdr));
        checkOutput("post_abort_done", 64'(done), 64'd0);
        exp_inj += CNT_EN ? 11 : 0;
        checkOutput("abort_inj", 64'(inj_count), 64'(exp_inj));
        driveInputs();

        // Reset in the middle of a run takes effect immediately, with no done.
        applyStimulus(10, 5, 0, 1'b0);
        done_seen = 0;
        repeat (7) @(posedge tx_clk);
        #3;
        tx_rst_n = 1'b0;
        #1;
        checkOutput("midrst_data", 64'(serdes_tx_data), 64'd0);
        checkOutput("midrst_hdr", 64'(serdes_tx_hdr), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_inj", 64'(inj_count), 64'd0);
        repeat (2) @(posedge tx_clk);
        #1;
        tx_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge tx_clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checkOutput("midrst_no_done", 64'(done_seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_tx_sh_inject.md
ETH_PHY_10G_TX_SH_INJECT -- requirements
Module: eth_phy_10g_tx_sh_inject

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the block payload width.
REQ-002 Parameter HDR_WIDTH, default 2, SHALL set the sync header width; only 2 is supported.
REQ-003 tx_clk  input  1  SHALL be the sole clock; all state updates occur on its rising edge.
REQ-004 tx_rst_n  input  1  SHALL be the reset: asynchronous assert, active-low, synchronous release to tx_clk.
REQ-005 in_data  input  DATA_WIDTH  SHALL carry the encoded/scrambled block payload from the TX encoder.
REQ-006 in_hdr  input  HDR_WIDTH  SHALL carry the block sync header (2'b01 data, 2'b10 control).
REQ-007 serdes_tx_data  output  DATA_WIDTH  SHALL carry the registered payload to the SERDES.
REQ-008 serdes_tx_hdr  output  HDR_WIDTH  SHALL carry the registered header, possibly corrupted.
REQ-009 start  input  1  SHALL be a one-cycle pulse that launches an injection run.
REQ-010 abort  input  1  SHALL terminate any run.
REQ-011 cfg_valid_cnt  input  7  SHALL set the number of untouched blocks per period (0..127).
REQ-012 cfg_invalid_cnt  input  6  SHALL set the number of corrupted blocks per period (0..63).
REQ-013 cfg_repeat  input  4  SHALL set the number of periods per run; 0 means run until abort.
REQ-014 cfg_bad_hdr  input  1  SHALL select the corrupt header: 0 -> 2'b00, 1 -> 2'b11.
REQ-015 busy  output  1  SHALL be high while the state is not IDLE.
REQ-016 done  output  1  SHALL pulse high for one cycle when a run completes normally.
REQ-017 inj_count  output  16  SHALL report the number of corrupted headers emitted.

Function
REQ-018 serdes_tx_data SHALL equal in_data delayed by exactly one tx_clk cycle, unconditionally.
REQ-019 serdes_tx_hdr SHALL equal the bad header if the state is INVALID in the sampling cycle, else in_hdr, with one cycle latency.
REQ-020 The FSM SHALL have states IDLE, VALID, INVALID.
REQ-021 In IDLE with start=1, cfg_* SHALL be latched and the next state SHALL be VALID, or INVALID if cfg_valid_cnt=0, or IDLE with a done pulse if both counts are 0.
REQ-022 VALID SHALL last exactly latched cfg_valid_cnt cycles, then go to INVALID; if latched cfg_invalid_cnt=0, it SHALL instead go to end-of-period.
REQ-023 INVALID SHALL last exactly latched cfg_invalid_cnt cycles, then go to end-of-period.
REQ-024 End-of-period: the remaining-period counter SHALL decrement; at 0 the FSM SHALL go to IDLE and pulse done; otherwise it SHALL restart at VALID (or INVALID if valid count=0).
REQ-025 With latched cfg_repeat=0, periods SHALL repeat indefinitely, with no decrement and no done.
REQ-026 start while busy SHALL be ignored; cfg_* changes during a run SHALL have no effect.
REQ-027 abort=1 SHALL force IDLE on the next edge with no done, and SHALL win over a simultaneous start; the header registered in that edge's sampling cycle follows REQ-019.
REQ-028 inj_count SHALL increment once per INVALID cycle, saturate at 16'hFFFF, and clear only on reset.

Reset
REQ-029 While tx_rst_n=0: state=IDLE, all counters 0, serdes_tx_data=0, serdes_tx_hdr=2'b01, busy=0, done=0, inj_count=0.
REQ-030 Reset asserted mid-run SHALL abandon the run without a done pulse.

Configuration
REQ-031 Macro ETH_PHY_TX_SH_INJECT_CNT_EN defined: inj_count SHALL be implemented per REQ-028.
REQ-032 Macro ETH_PHY_TX_SH_INJECT_CNT_EN undefined: inj_count SHALL be tied to 0, with no counter logic; all other behaviour is identical.

Verification
REQ-033 valid=64, invalid=1, repeat=5, hdr input 2'b01 -> five runs of 64 x 2'b01 then one 2'b00; done pulses once; inj_count=5.
REQ-034 valid=64, invalid=15, repeat=5, cfg_bad_hdr=1 -> each period is 64 x 2'b01 then 15 x 2'b11; inj_count=75; paired RX keeps block lock.
REQ-035 valid=64, invalid=16, repeat=1 -> exactly 16 corrupted headers; paired RX drops block lock; done pulses 1 cycle after the last corrupted block is sampled.
REQ-036 valid=0, invalid=3, repeat=0, abort after 10 cycles -> every header corrupted until abort, no done, busy falls 1 cycle after abort.
REQ-037 start pulsed while busy, and tx_rst_n pulsed low mid-run -> second start ignored; reset yields the REQ-029 values immediately, with no done.
REQ-038 Macro undefined, REQ-033 stimulus repeated -> same headers; inj_count stays 0.
